// File: rtl/alu_op_scheduler.sv
// Issue stage for the 16-bit ALU: request FIFO, IDLE/ISSUE/CAPTURE/HOLD sequencer, tagged result return.
// Optional opcode checking is compiled in with ALU_SCHED_ERR_CHECK_EN.
`timescale 1ns/1ps
module alu_op_scheduler #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_opcode,
   input  logic [15:0]              in_a,
   input  logic [15:0]              in_b,
   input  logic [TAG_W-1:0]         in_tag,
   output logic [15:0]              alu_operandA,
   output logic [15:0]              alu_operandB,
   output logic [3:0]               alu_opcode,
   input  logic [31:0]              alu_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_error,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENTRY_W = 4 + 16 + 16 + TAG_W;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

   state_t             state_reg, state_next;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [3:0]         issue_opcode_reg;
   logic [15:0]        issue_a_reg, issue_b_reg;
   logic [TAG_W-1:0]   issue_tag_reg;
   logic [31:0]        out_result_reg;
   logic [TAG_W-1:0]   out_tag_reg;
   logic               out_error_reg;
   logic               push, pop;
   logic [31:0]        cap_result;
   logic               cap_error;

   assign in_ready = (count_reg != FULL);
   assign push     = in_valid && in_ready;

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:   state_next = CAPTURE;
         CAPTURE: state_next = HOLD;
         HOLD: begin
            if (out_ready) begin
               if (count_reg != '0) begin
                  pop        = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Storage carries no reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= {in_opcode, in_a, in_b, in_tag};
   end

`ifdef ALU_SCHED_ERR_CHECK_EN
   logic illegal_op, div_zero;
   always_comb begin
      illegal_op = (issue_opcode_reg >= 4'd11);
      div_zero   = (issue_opcode_reg == 4'd3) && (issue_b_reg == 16'd0);
      cap_error  = illegal_op || div_zero;
      cap_result = illegal_op ? 32'd0 : alu_result;
   end
`else
   assign cap_error  = 1'b0;
   assign cap_result = alu_result;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         issue_opcode_reg <= '0;
         issue_a_reg      <= '0;
         issue_b_reg      <= '0;
         issue_tag_reg    <= '0;
         out_result_reg   <= '0;
         out_tag_reg      <= '0;
         out_error_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            {issue_opcode_reg, issue_a_reg, issue_b_reg, issue_tag_reg} <= mem[rd_ptr_reg];
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         // ALU result registered at the end of ISSUE is visible here.
         if (state_reg == CAPTURE) begin
            out_result_reg <= cap_result;
            out_tag_reg    <= issue_tag_reg;
            out_error_reg  <= cap_error;
         end
      end
   end

   assign alu_operandA = issue_a_reg;
   assign alu_operandB = issue_b_reg;
   assign alu_opcode   = issue_opcode_reg;
   assign out_valid    = (state_reg == HOLD);
   assign out_result   = out_result_reg;
   assign out_tag      = out_tag_reg;
   assign out_error    = out_error_reg;
   assign fifo_count   = count_reg;
   assign busy         = (state_reg != IDLE) || (count_reg != '0);
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: table-driven single ops, directed corner sequences, random traffic
// checked by an in-order scoreboard fed from an arithmetic ALU reference.
`timescale 1ns/1ps
module tb_alu_op_scheduler;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_opcode = '0;
   logic [15:0]       in_a = '0, in_b = '0;
   logic [TAG_W-1:0]  in_tag = '0;
   logic [15:0]       alu_operandA, alu_operandB;
   logic [3:0]        alu_opcode;
   logic [31:0]       alu_result = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_result;
   logic [TAG_W-1:0]  out_tag;
   logic              out_error;
   logic [$clog2(DEPTH):0] fifo_count;
   logic              busy;

   int tests = 0;
   int fails = 0;

   alu_op_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_opcode(alu_opcode),
      .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_error(out_error), .fifo_count(fifo_count), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic signed [15:0] a,
                                           input logic signed [15:0] b);
      int ia;
      int ib;
      ia = a;
      ib = b;
      case (op)
         4'd0:    return 32'(ia + ib);
         4'd1:    return 32'(ia - ib);
         4'd2:    return 32'(ia * ib);
         4'd3:    return (ib == 0) ? 32'hFFFF_FFFF : 32'(ia / ib);
         4'd4:    return {16'h0, a & b};
         4'd5:    return {16'h0, a | b};
         4'd6:    return {16'h0, a ^ b};
         4'd9:    return 32'(ia + 1);
         4'd10:   return 32'(ia - 1);
         default: return {a, b};
      endcase
   endfunction

   // Registered ALU stand-in: one cycle from operands to result.
   always @(posedge clk) alu_result <= ref_alu(alu_opcode, alu_operandA, alu_operandB);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         $display("[TB] ok %s = %h", name, act);
      end
   endtask

   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;
   exp_t exp_q[$];

   // Monitor samples 1 ns before each rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         tests++;
         if (in_ready !== (fifo_count != DEPTH) || fifo_count > DEPTH) begin
            fails++;
            $display("FAIL ready_vs_count: in_ready=%b fifo_count=%0d", in_ready, fifo_count);
         end
         if (reset_n && in_valid && in_ready) begin
            exp_t e;
            e.res = ref_alu(in_opcode, in_a, in_b);
            e.tag = in_tag;
            e.err = 1'b0;
`ifdef ALU_SCHED_ERR_CHECK_EN
            if (in_opcode >= 4'd11) begin
               e.res = 32'd0;
               e.err = 1'b1;
            end else if (in_opcode == 4'd3 && in_b == 16'd0) begin
               e.err = 1'b1;
            end
`endif
            exp_q.push_back(e);
         end
         if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_result", 32'(out_tag), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_result", out_result, e.res);
               check("sb_tag", 32'(out_tag), 32'(e.tag));
               check("sb_error", 32'(out_error), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected under 2000000", $time);
      $fatal(1, "watchdog");
   end

   // Called just after a falling edge; returns just after the falling edge following acceptance.
   task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [TAG_W-1:0] tag, output int waits);
      logic rdy;
      in_opcode = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      waits = 0;
      rdy = 1'b0;
      while (!rdy && waits <= 50) begin
         #4;
         rdy = in_ready;
         @(negedge clk);
         if (!rdy) waits++;
      end
      if (!rdy) check("push_timeout", 32'(waits), 32'd0);
   endtask

   task automatic wait_out_valid(input string name, output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_idle", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [3:0]       op;
      logic [15:0]      a, b;
      logic [TAG_W-1:0] tag;
      logic [31:0]      exp_res;
      logic             exp_err;
   } vec_t;

   initial begin
      vec_t vecs[9];
      int   w, n, t, prev;
      logic stale;

      vecs[0] = '{4'd0,  16'd5,      16'hFFFD, 4'd2,  32'd2,          1'b0};
      vecs[1] = '{4'd1,  16'd10,     16'd20,   4'd3,  32'hFFFF_FFF6,  1'b0};
      vecs[2] = '{4'd2,  16'hFED4,   16'd200,  4'd4,  32'hFFFF_15A0,  1'b0};
      vecs[3] = '{4'd3,  16'd100,    16'd7,    4'd5,  32'h0000_000E,  1'b0};
      vecs[4] = '{4'd9,  16'h7FFF,   16'd0,    4'd6,  32'h0000_8000,  1'b0};
      vecs[5] = '{4'd10, 16'h8000,   16'd1,    4'd7,  32'hFFFF_7FFF,  1'b0};
`ifdef ALU_SCHED_ERR_CHECK_EN
      vecs[6] = '{4'd12, 16'h1234,   16'h5678, 4'd8,  32'h0000_0000,  1'b1};
      vecs[7] = '{4'd3,  16'd50,     16'd0,    4'd9,  32'hFFFF_FFFF,  1'b1};
`else
      vecs[6] = '{4'd12, 16'h1234,   16'h5678, 4'd8,  32'h1234_5678,  1'b0};
      vecs[7] = '{4'd3,  16'd50,     16'd0,    4'd9,  32'hFFFF_FFFF,  1'b0};
`endif
      vecs[8] = '{4'd6,  16'h00FF,   16'h0F0F, 4'd10, 32'h0000_0FF0,  1'b0};

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_error", 32'(out_error), 32'd0);
      check("rst_alu_ops", {alu_operandA, alu_operandB}, 32'd0);
      check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single operations: latency and values against the table.
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, w);
         in_valid = 1'b0;
         @(negedge clk);
         check("issue_operandA", 32'(alu_operandA), 32'(vecs[i].a));
         check("issue_opcode", 32'(alu_opcode), 32'(vecs[i].op));
         wait_out_valid("single_out_valid", n);
         check("single_latency", 32'(n + 1), 32'd3);
         check("single_result", out_result, vecs[i].exp_res);
         check("single_tag", 32'(out_tag), 32'(vecs[i].tag));
         check("single_error", 32'(out_error), 32'(vecs[i].exp_err));
         @(negedge clk);
         @(negedge clk);
      end
      drain();

      // Burst under back-pressure: one op reaches the issue register, four fill the FIFO.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push(4'd0, 16'(k * 3), 16'd1, TAG_W'(k), w);
         check("burst_accept_wait", 32'(w), 32'd0);
      end
      check("burst_full_ready", 32'(in_ready), 32'd0);
      check("burst_full_count", 32'(fifo_count), 32'(DEPTH));
      @(negedge clk);
      check("burst_stall_count", 32'(fifo_count), 32'(DEPTH));
      fork
         begin
            push(4'd1, 16'd0, 16'd5, TAG_W'(5), w);
            in_valid = 1'b0;
         end
         begin
            out_ready = 1'b1;
            t = 0;
            prev = 0;
            for (int k = 0; k < 6; k++) begin
               n = 0;
               while (!out_valid && n < 20) begin
                  @(negedge clk);
                  t++;
                  n++;
               end
               check("burst_valid", 32'(out_valid), 32'd1);
               check("burst_tag_order", 32'(out_tag), 32'(k));
               if (k > 0) check("burst_cadence", 32'(t - prev), 32'd3);
               prev = t;
               @(negedge clk);
               t++;
            end
         end
      join
      drain();

      // Reset while CAPTURE is in progress with three entries queued.
      out_ready = 1'b0;
      push(4'd0, 16'd1, 16'd1, 4'd9, w);
      for (int k = 0; k < 4; k++) push(4'd2, 16'd7, 16'(k), TAG_W'(10 + k), w);
      in_valid = 1'b0;
      wait_out_valid("rstmid_hold", n);
      check("rstmid_full", 32'(fifo_count), 32'(DEPTH));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      check("rstmid_queued", 32'(fifo_count), 32'd3);
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("rstmid_async_valid", 32'(out_valid), 32'd0);
      check("rstmid_async_count", 32'(fifo_count), 32'd0);
      check("rstmid_async_alu", 32'(alu_operandA), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rstmid_in_ready", 32'(in_ready), 32'd1);
      check("rstmid_count", 32'(fifo_count), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      out_ready = 1'b1;
      stale = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check("rstmid_no_stale", 32'(stale), 32'd0);

      // Simultaneous push and pop at count 2; pointers wrap repeatedly.
      for (int r = 0; r < 3; r++) begin
         out_ready = 1'b0;
         push(4'd0, 16'(r), 16'd100, TAG_W'(1), w);
         push(4'd1, 16'(r), 16'd3, TAG_W'(2), w);
         push(4'd2, 16'(r), 16'd4, TAG_W'(3), w);
         in_valid = 1'b0;
         wait_out_valid("pp_hold", n);
         check("pp_count_before", 32'(fifo_count), 32'd2);
         out_ready = 1'b1;
         push(4'd6, 16'hAAAA, 16'(r), TAG_W'(4), w);
         in_valid = 1'b0;
         check("pp_accept_wait", 32'(w), 32'd0);
         check("pp_count_after", 32'(fifo_count), 32'd2);
         drain();
      end

      // Random traffic against the scoreboard.
      for (int c = 0; c < 1500; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_opcode = 4'($urandom_range(0, 15));
         in_a      = 16'($urandom);
         in_b      = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         in_tag    = TAG_W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
